// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and the decode->execute control bundle for the pipeline chain
package pipe_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;
  localparam int DEFAULT_CNT_W  = 32;

  // Packed so the CPU top can drop it straight into a WIDTH-bit payload.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] alu_op;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       branch;
    logic       jump;
    logic [7:0] imm;
  } dec_ex_ctrl_t;

  localparam int DEC_EX_CTRL_W = $bits(dec_ex_ctrl_t);

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data pipeline register; kill beats enable beats hold
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_kill,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Bubbles carry zero data so dead payload never leaks downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - STAGES-deep register chain with stall/flush/back-pressure; PIPE_PERF_CNT_EN enables perf counters
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall_i,
  input  logic [STAGES-1:0]       flush_i,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [STAGES-1:0]       stage_valid_o,
  output logic [STAGES*WIDTH-1:0] stage_data_o,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic [CNT_W-1:0]        flush_cnt,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic [STAGES:0]   w_hold;
  logic [STAGES-1:0] w_kill;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_in_valid;
  logic              w_anyflush;
  logic [WIDTH-1:0]  w_stage_data [STAGES];
  logic [WIDTH-1:0]  w_in_data    [STAGES];

  assign w_anyflush = |flush_i;

  // Hold ripples from the consumer back to stage 0; an empty stage never holds unless stalled.
  always_comb begin
    w_hold         = '0;
    w_hold[STAGES] = !out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_hold[k] = stall_i[k] | (w_valid[k] & w_hold[k+1]);
    end
  end

  always_comb begin
    w_kill             = '0;
    w_kill[STAGES-1]   = flush_i[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_kill[k] = flush_i[k] | w_kill[k+1];
    end
  end

  always_comb begin
    w_in_valid    = '0;
    w_in_valid[0] = in_valid & !w_anyflush;
    w_in_data[0]  = in_data;
    for (int k = 1; k < STAGES; k++) begin
      w_in_valid[k] = w_valid[k-1] & !w_kill[k-1];
      w_in_data[k]  = w_stage_data[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_kill  (w_kill[g]),
      .i_en    (!w_hold[g]),
      .i_valid (w_in_valid[g]),
      .i_data  (w_in_data[g]),
      .o_valid (w_valid[g]),
      .o_data  (w_stage_data[g])
    );
    assign stage_data_o[g*WIDTH +: WIDTH] = w_stage_data[g];
  end

  assign stage_valid_o = w_valid;
  assign in_ready      = !w_hold[0] & !w_anyflush;
  assign out_valid     = w_valid[STAGES-1] & !flush_i[STAGES-1];
  assign out_data      = w_stage_data[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  logic             w_retire_evt;
  logic             w_flush_evt;
  logic             w_stall_evt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_retire_evt = out_valid & out_ready;
  assign w_flush_evt  = w_anyflush & (|(w_valid & w_kill));
  assign w_stall_evt  = in_valid & !in_ready;

  // Counters saturate rather than wrap so long runs never read as small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
      r_flush_cnt  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_retire_evt && r_retire_cnt != '1) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_flush_evt && r_flush_cnt != '1)   r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
      if (w_stall_evt && r_stall_cnt != '1)   r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  assign retire_cnt = '0;
  assign flush_cnt  = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;

  localparam int W = 32;
  localparam int S = 4;
  localparam int C = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [S-1:0]   stall_i;
  logic [S-1:0]   flush_i;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [S-1:0]   stage_valid_o;
  logic [S*W-1:0] stage_data_o;
  logic [C-1:0]   retire_cnt;
  logic [C-1:0]   flush_cnt;
  logic [C-1:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .stage_valid_o (stage_valid_o),
    .stage_data_o  (stage_data_o),
    .retire_cnt    (retire_cnt),
    .flush_cnt     (flush_cnt),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    stall_i = '0; flush_i = '0; out_ready = 1'b1;
    #3;
    check("rst_valid", stage_valid_o, 0);
    check("rst_data", stage_data_o, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_retire", retire_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // streaming
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h10 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, 32'h10 + 32'(i));
      tick();
    end
    check("stream_drained", out_valid, 0);
    check("stream_retire", retire_cnt, cexp(4));

    // back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h20 + 32'(i);
      tick();
    end
    in_data = 32'h24;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_data", stage_data_o, {32'h20, 32'h21, 32'h22, 32'h23});
      check("bp_valid", stage_valid_o, 4'b1111);
    end
    check("bp_stall_cnt", stall_cnt, cexp(3));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 32'h20 + 32'(i));
      tick();
    end
    check("bp_drained", out_valid, 0);
    check("bp_retire", retire_cnt, cexp(8));

    // bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h30; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 32'h31; tick();
    in_data = 32'h32; tick();
    #1;
    check("bub_pre_valid", stage_valid_o, 4'b1011);
    in_data = 32'h33;
    #1;
    check("bub_in_ready", in_ready, 1);
    tick();
    check("bub_valid", stage_valid_o, 4'b1111);
    check("bub_data", stage_data_o, {32'h30, 32'h31, 32'h32, 32'h33});
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("bub_out_data", out_data, 32'h30 + 32'(i));
      tick();
    end
    check("bub_retire", retire_cnt, cexp(12));
    check("bub_stall_cnt", stall_cnt, cexp(3));

    // flush
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h43 - 32'(i);
      tick();
    end
    in_data   = 32'h44;
    out_ready = 1'b1;
    flush_i   = 4'b0100;
    #1;
    check("fl_in_ready", in_ready, 0);
    check("fl_out_valid", out_valid, 1);
    check("fl_out_data", out_data, 32'h43);
    tick();
    flush_i  = '0;
    in_valid = 1'b0;
    #1;
    check("fl_valid", stage_valid_o, 0);
    check("fl_data", stage_data_o, 0);
    check("fl_retire", retire_cnt, cexp(13));
    check("fl_flush_cnt", flush_cnt, cexp(1));
    check("fl_stall_cnt", stall_cnt, cexp(4));
    for (int i = 0; i < 3; i++) begin
      check("fl_no_ghost", out_valid, 0);
      tick();
    end

    // stall / flush priority
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h50; tick();
    in_data = 32'h51; tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stall_i   = 4'b0010;
    #1;
    check("pr_in_ready", in_ready, 0);
    tick();
    check("pr_hold_valid", stage_valid_o[1:0], 2'b11);
    check("pr_hold_data", stage_data_o[63:0], {32'h50, 32'h51});
    flush_i = 4'b0010;
    tick();
    check("pr_flush_valid", stage_valid_o[1:0], 2'b00);
    check("pr_flush_data", stage_data_o[63:0], 0);
    check("pr_flush_cnt", flush_cnt, cexp(2));
    flush_i = '0;
    stall_i = '0;
    tick();
    tick();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h60 + 32'(i);
      tick();
    end
    check("ar_pre_valid", stage_valid_o, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", stage_valid_o, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_retire", retire_cnt, 0);
    check("ar_flush", flush_cnt, 0);
    check("ar_stall", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised pipeline-register chain that replaces the hand-written fetch→decode→execute register blocks in the pipelined CPU top. It carries an opaque payload through STAGES register boundaries. Each stage has its own stall and flush controls, a valid bit, and downstream back-pressure with bubble collapse. Optional performance counters report retired, flushed and stalled activity.

## Interface
- WIDTH, 32: payload bits per stage (packed control and data fields).
- STAGES, 4: number of register boundaries, ≥1. Stage 0 is the youngest; stage STAGES-1 is the oldest.
- CNT_W, 32: performance-counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer offers in_data.
- in_data  in  WIDTH  payload entering stage 0.
- in_ready  out  1  chain accepts in_data this cycle.
- stall_i  in  STAGES  per-stage hold request.
- flush_i  in  STAGES  per-stage kill; bit k kills stages 0..k.
- out_ready  in  1  consumer accepts the oldest stage.
- out_valid  out  1  oldest stage holds a live entry.
- out_data  out  WIDTH  payload of stage STAGES-1.
- stage_valid_o  out  STAGES  valid bit of every stage.
- stage_data_o  out  STAGES*WIDTH  payload of every stage; stage k occupies bits [k*WIDTH +: WIDTH].
- retire_cnt, flush_cnt, stall_cnt  out  CNT_W each  performance counters.

## Operation
- Let hold[STAGES] = !out_ready and hold[k] = stall_i[k] | (valid[k] & hold[k+1]); en[k] = !hold[k].
- Bubble collapse: an invalid stage loads even when downstream holds, unless stall_i[k] is set.
- kill[k] = OR of flush_i[m] for all m ≥ k; anyflush = |flush_i.
- Incoming valid for stage 0 = in_valid & !anyflush. Incoming valid for stage j>0 = valid[j-1] & !kill[j-1].
- Next state, stage k:
  - If kill[k]: valid←0, data←0. Flush beats stall.
  - Else if en[k]: valid←incoming valid; data←incoming data, or 0 when incoming is invalid.
  - Else: hold.
- in_ready = en[0] & !anyflush. An input is consumed when in_valid & in_ready.
- out_valid = valid[STAGES-1] & !flush_i[STAGES-1]. Retire occurs when out_valid & out_ready.
- A killed entry is never presented, duplicated or retired. Stalled entries are never lost.
- Asserting stall_i on an invalid stage holds a bubble.

## Timing
- Reset: all valid 0, all data 0, all counters 0, out_valid 0.
  - in_ready is combinational; during reset it reads 1 when stall_i[0]=0 and flush_i=0.
- Latency with no holds: an entry accepted at edge n is visible on out_data after edge n+STAGES-1, i.e. STAGES cycles in flight.
- Throughput: one entry per cycle when out_ready=1 and no stalls or flushes are active.
- Combinational paths: out_ready→in_ready (hold ripple) and flush_i→in_ready/out_valid. No registered skid.
- Reset mid-operation clears every stage immediately. Any in-flight entries are discarded.
- STAGES=1: stage 0 is both input and output stage; all rules still apply.

## Configuration
- PIPE_PERF_CNT_EN defined: counters are active and saturate at 2^CNT_W-1.
  - retire_cnt increments once per retire.
  - flush_cnt increments once per cycle with anyflush and at least one valid entry in the killed range.
  - stall_cnt increments once per cycle with in_valid & !in_ready.
- PIPE_PERF_CNT_EN undefined: counter ports remain present, are tied to 0, and no counter flops are built.

## Structure
- Package pipe_pkg holds:
  - default WIDTH/STAGES/CNT_W constants;
  - a typedef for the CPU's decode→execute control bundle, so the CPU top packs and unpacks it into WIDTH.
- Sub-module pipe_stage: one valid+data register implementing the kill/en/hold priority. It is instantiated STAGES times in a generate loop.
- Hold/kill ripple logic and the counters live in pipe_stage_chain.

## Test plan
- Reset: assert rst mid-stream with 4 live entries → stage_valid_o=0000, out_valid=0, counters 0 immediately, without waiting for a clock.
- Streaming: push 0x10,0x11,0x12,0x13 on consecutive cycles, out_ready=1 → out_data 0x10..0x13 on 4 consecutive cycles starting 4 cycles after the first accept; retire_cnt=4.
- Back-pressure: fill all stages, out_ready=0 for 3 cycles → in_ready=0, stage_data_o unchanged, stall_cnt +3 with in_valid=1; release → all entries retire in order with no duplicates.
- Bubble collapse: stage 2 empty, out_ready=0, stages 0,1 valid → after one edge stages 1,2 valid, stage 0 accepts a new entry, in_ready=1.
- Flush: stages hold A(0),B(1),C(2),D(3), pulse flush_i=0100 with out_ready=1 → D retires, stages 0..3 become invalid and data 0, in_ready=0 that cycle, flush_cnt +1, A/B/C never appear on out_data.
- Priority: stall_i[1]=1 together with flush_i[1]=1 → stage 1 cleared, flush wins; flush_i=0000 with stall_i[1]=1 → stage 1 and stage 0 hold.
